// File: rtl/periph_dma_master.sv
// periph_dma_master
//   Word-copy DMA initiator on the peripherals io_* bus. A CPU pulse on start
//   latches src/dst/len. The engine then reads one word from src, writes it to
//   dst, and advances both by 4. It repeats this until len words are moved,
//   then pulses done_int. Misaligned addresses, a beat timeout, or an abort
//   end the transfer in ERR and set the sticky err flag.
// Ports
//   pclk, rst_n         clock, async active-low reset
//   start, abort        CPU control (start pulse / stop request)
//   src_addr, dst_addr  word-aligned byte addresses
//   len                 number of 32-bit words to copy
//   busy, done_int, err status to the CPU
//   io_addr, io_read, io_write, io_wdata, io_byte_size, read_ready
//                       request side of the bus
//   io_rdata, io_ready  responder side of the bus
module periph_dma_master #(
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 1024,
   parameter int XLEN    = 32,
   parameter int DATA_W  = 32
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [XLEN-1:0]   src_addr,
   input  logic [XLEN-1:0]   dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done_int,
   output logic              err,
   output logic [XLEN-1:0]   io_addr,
   output logic              io_read,
   output logic              io_write,
   output logic [DATA_W-1:0] io_wdata,
   output logic [1:0]        io_byte_size,
   output logic              read_ready,
   input  logic [DATA_W-1:0] io_rdata,
   input  logic              io_ready
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_ACK, S_WR_REQ, S_GAP, S_DONE, S_ERR
   } state_t;

   state_t             state, state_n;
   logic [XLEN-1:0]    src, dst;
   logic [LEN_W-1:0]   cnt;
   logic [DATA_W-1:0]  rd_buf;
   logic [TW-1:0]      timer;
   logic               err_q;
   logic               abort_pend;   // abort seen outside a request state
   logic               gap_after_rd; // selects where GAP goes next
   logic               tmo;
   logic               abort_any;

   assign tmo       = (timer == TW'(TIMEOUT - 1)) && !io_ready;
   assign abort_any = abort | abort_pend;

   // Outputs decode straight from state, so an async reset drops them at once.
   always_comb begin
      state_n      = state;
      io_addr      = '0;
      io_read      = 1'b0;
      io_write     = 1'b0;
      io_wdata     = '0;
      io_byte_size = 2'd0;
      read_ready   = 1'b0;
      done_int     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if ((|src_addr[1:0]) || (|dst_addr[1:0])) state_n = S_ERR;
               else if (len == '0)                       state_n = S_DONE;
               else                                      state_n = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            io_read      = 1'b1;
            io_addr      = src;
            io_byte_size = 2'd2;
            // Abort beats a completing beat: nothing downstream has started yet.
            if (abort)         state_n = S_ERR;
            else if (io_ready) state_n = S_RD_ACK;
            else if (tmo)      state_n = S_ERR;
         end
         S_RD_ACK: begin
            read_ready = 1'b1;
            state_n    = abort_any ? S_ERR : S_GAP;
         end
         S_WR_REQ: begin
            io_write     = 1'b1;
            io_addr      = dst;
            io_wdata     = rd_buf;
            io_byte_size = 2'd2;
            if (abort)         state_n = S_ERR;
            else if (io_ready) state_n = S_GAP;
            else if (tmo)      state_n = S_ERR;
         end
         S_GAP: begin
            // Hold until the responder releases io_ready so its decode can drop.
            if (!io_ready) begin
               if (abort_any)         state_n = S_ERR;
               else if (gap_after_rd) state_n = S_WR_REQ;
               else if (cnt == '0)    state_n = S_DONE;
               else                   state_n = S_RD_REQ;
            end
         end
         S_DONE: begin
            done_int = 1'b1;
            state_n  = S_IDLE;
         end
         S_ERR:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE) && (state != S_ERR);
   assign err  = err_q;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         src          <= '0;
         dst          <= '0;
         cnt          <= '0;
         rd_buf       <= '0;
         timer        <= '0;
         err_q        <= 1'b0;
         abort_pend   <= 1'b0;
         gap_after_rd <= 1'b0;
      end else begin
         state <= state_n;

         case (state)
            S_IDLE: begin
               abort_pend <= 1'b0;
               if (start) begin
                  err_q <= 1'b0;
                  src   <= src_addr;
                  dst   <= dst_addr;
                  cnt   <= len;
               end
            end
            S_RD_REQ: if (io_ready) rd_buf <= io_rdata;
            S_RD_ACK: begin
               gap_after_rd <= 1'b1;
               if (abort) abort_pend <= 1'b1;
            end
            S_WR_REQ: begin
               gap_after_rd <= 1'b0;
               if (io_ready && !abort) begin
                  src <= src + XLEN'(4);
                  dst <= dst + XLEN'(4);
                  cnt <= cnt - LEN_W'(1);
               end
            end
            S_GAP: if (abort) abort_pend <= 1'b1;
            default: ;
         endcase

         // Set after the IDLE clear so a misaligned start still flags.
         if (state_n == S_ERR && state != S_ERR) err_q <= 1'b1;

         if ((state_n == S_RD_REQ || state_n == S_WR_REQ) && state_n != state)
            timer <= '0;
         else if ((state == S_RD_REQ || state == S_WR_REQ) && !io_ready)
            timer <= timer + TW'(1);
      end
   end

endmodule

// File: tb/tb_periph_dma_master.sv
module tb_periph_dma_master;

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic [15:0] len = '0;
   logic        busy, done_int, err;
   logic [31:0] io_addr, io_wdata, io_rdata;
   logic        io_read, io_write, read_ready, io_ready;
   logic [1:0]  io_byte_size;

   always #5 pclk = ~pclk;

   periph_dma_master #(.LEN_W(16), .TIMEOUT(16), .XLEN(32), .DATA_W(32)) dut (
      .pclk(pclk), .rst_n(rst_n), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done_int(done_int), .err(err),
      .io_addr(io_addr), .io_read(io_read), .io_write(io_write),
      .io_wdata(io_wdata), .io_byte_size(io_byte_size), .read_ready(read_ready),
      .io_rdata(io_rdata), .io_ready(io_ready)
   );

   // responder: data is a fixed function of the address
   function automatic logic [31:0] pat(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1234_5678;
   endfunction

   int wait_cfg = 0, linger_cfg = 0;
   bit no_wr_ready = 1'b0;
   int wcnt = 0, lcnt = 0;
   logic req;
   assign req      = io_read | io_write;
   assign io_ready = (req && wcnt >= wait_cfg && !(io_write && no_wr_ready)) || (lcnt != 0);
   assign io_rdata = io_read ? pat(io_addr) : 32'hDEAD_BEEF;

   typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] data; } ev_t;
   ev_t evq[$];
   ev_t ev;
   int n_rr = 0, n_rr2 = 0, n_both = 0, n_early = 0, n_done = 0, n_wrcyc = 0;
   logic rr_prev = 1'b0, req_prev = 1'b0;

   always @(posedge pclk) begin
      if (!req) wcnt <= 0; else if (!io_ready) wcnt <= wcnt + 1;
      if (req && io_ready) lcnt <= linger_cfg; else if (lcnt != 0) lcnt <= lcnt - 1;
      if (req && io_ready) begin
         ev = {io_write, io_addr, io_write ? io_wdata : io_rdata};
         evq.push_back(ev);
      end
      if (read_ready) n_rr <= n_rr + 1;
      if (read_ready && rr_prev) n_rr2 <= n_rr2 + 1;
      if (io_read && io_write) n_both <= n_both + 1;
      if (req && !req_prev && lcnt != 0) n_early <= n_early + 1;
      if (done_int) n_done <= n_done + 1;
      if (io_write) n_wrcyc <= n_wrcyc + 1;
      rr_prev  <= read_ready;
      req_prev <= req;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                           input logic ab);
      @(negedge pclk);
      src_addr = s; dst_addr = d; len = l; start = 1'b1; abort = ab;
      @(negedge pclk);
      start = 1'b0; abort = 1'b0;
   endtask

   // called at the first negedge after the start edge
   task automatic wait_idle(output int nb, output int nd);
      bit to;
      nb = 0; nd = 0; to = 1'b1;
      for (int c = 1; c <= 2000; c++) begin
         if (busy) nb++;
         if (done_int) nd++;
         if (!busy && c >= 2) begin to = 1'b0; break; end
         @(negedge pclk);
      end
      checks++;
      if (to) begin
         errors++;
         $display("FAIL wait_idle actual=busy required=idle within 2000 cycles");
      end
   endtask

   typedef struct {
      logic [31:0] src, dst;
      logic [15:0] len;
      int wt, lg;
      bit exp_err;
      int exp_done, exp_busy;
   } vec_t;
   vec_t vecs[7];

   initial begin
      int nb, nd, base, rr0, wc0, dn0, n;
      logic [31:0] a, d;

      vecs[0] = '{32'h0000_0100, 32'h0000_0200, 16'd3, 0, 0, 1'b0, 1, 16};
      vecs[1] = '{32'h0000_0400, 32'h0000_0500, 16'd1, 5, 2, 1'b0, 1, 19};
      vecs[2] = '{32'hFFFF_FFF8, 32'h0000_0300, 16'd3, 1, 1, 1'b0, 1, 0};
      vecs[3] = '{32'h0000_0102, 32'h0000_0200, 16'd2, 0, 0, 1'b1, 0, 0};
      vecs[4] = '{32'h0000_0100, 32'h0000_0203, 16'd2, 0, 0, 1'b1, 0, 0};
      vecs[5] = '{32'h0000_0010, 32'h0000_0020, 16'd0, 0, 0, 1'b0, 1, 1};
      vecs[6] = '{32'h0000_0100, 32'hFFFF_FFFC, 16'd2, 2, 0, 1'b0, 1, 0};

      // reset state
      #12;
      chk("reset_outs", 64'({busy, done_int, err, io_read, io_write, read_ready, io_byte_size}), 64'd0);
      chk("reset_bus", {io_addr, io_wdata}, 64'd0);
      @(negedge pclk); rst_n = 1'b1;

      // table of complete transfers
      for (int v = 0; v < 7; v++) begin
         wait_cfg = vecs[v].wt; linger_cfg = vecs[v].lg;
         base = evq.size(); rr0 = n_rr;
         do_start(vecs[v].src, vecs[v].dst, vecs[v].len, 1'b0);
         wait_idle(nb, nd);
         chk($sformatf("v%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
         chk($sformatf("v%0d_done", v), 64'(nd), 64'(vecs[v].exp_done));
         n = vecs[v].exp_err ? 0 : 2 * int'(vecs[v].len);
         chk($sformatf("v%0d_beats", v), 64'(evq.size() - base), 64'(n));
         chk($sformatf("v%0d_rr", v), 64'(n_rr - rr0), 64'(n / 2));
         if (vecs[v].exp_busy != 0)
            chk($sformatf("v%0d_busy_cycles", v), 64'(nb), 64'(vecs[v].exp_busy));
         if (evq.size() - base == n) begin
            for (int i = 0; i < n / 2; i++) begin
               a = vecs[v].src + 32'(4 * i);
               d = vecs[v].dst + 32'(4 * i);
               ev = evq[base + 2 * i];
               chk($sformatf("v%0d_rd%0d", v, i), {31'd0, ev.wr, ev.addr}, {31'd0, 1'b0, a});
               chk($sformatf("v%0d_rd%0d_data", v, i), 64'(ev.data), 64'(pat(a)));
               ev = evq[base + 2 * i + 1];
               chk($sformatf("v%0d_wr%0d", v, i), {31'd0, ev.wr, ev.addr}, {31'd0, 1'b1, d});
               chk($sformatf("v%0d_wr%0d_data", v, i), 64'(ev.data), 64'(pat(a)));
            end
         end
      end
      wait_cfg = 0; linger_cfg = 0;

      // len=0: done_int one cycle after start, no bus cycle
      base = evq.size();
      do_start(32'h40, 32'h80, 16'd0, 1'b0);
      chk("len0_c1", 64'({done_int, busy, io_read, io_write}), 64'b1100);
      @(negedge pclk);
      chk("len0_c2", 64'({done_int, busy}), 64'b00);
      chk("len0_nobus", 64'(evq.size() - base), 64'd0);

      // misaligned start: err next cycle, sticky, cleared by next valid start
      do_start(32'h102, 32'h200, 16'd1, 1'b0);
      chk("mis_c1", 64'({err, busy, io_read, io_write}), 64'b1000);
      @(negedge pclk); @(negedge pclk);
      chk("mis_sticky", 64'(err), 64'd1);
      do_start(32'h100, 32'h200, 16'd1, 1'b0);
      chk("mis_clear", 64'({err, io_read}), 64'b01);
      wait_idle(nb, nd);
      chk("mis_after_done", 64'({err, 1'b0}) | 64'(nd), 64'd1);

      // write timeout: io_write held exactly 16 cycles then err
      no_wr_ready = 1'b1; base = evq.size(); wc0 = n_wrcyc; dn0 = n_done;
      do_start(32'h100, 32'h200, 16'd1, 1'b0);
      wait_idle(nb, nd);
      chk("tmo_wr_cycles", 64'(n_wrcyc - wc0), 64'd16);
      chk("tmo_err", 64'({err, io_write}), 64'b10);
      chk("tmo_beats", 64'(evq.size() - base), 64'd1);
      chk("tmo_done", 64'(n_done - dn0), 64'd0);
      no_wr_ready = 1'b0;

      // abort mid RD_REQ: request dropped next cycle, no write ever issued
      wait_cfg = 8; wc0 = n_wrcyc;
      do_start(32'h100, 32'h200, 16'd2, 1'b0);
      @(negedge pclk); @(negedge pclk);
      chk("abort_pre", 64'(io_read), 64'd1);
      abort = 1'b1;
      @(negedge pclk);
      abort = 1'b0;
      chk("abort_drop", 64'({io_read, err, busy}), 64'b010);
      @(negedge pclk); @(negedge pclk);
      chk("abort_no_write", 64'(n_wrcyc - wc0), 64'd0);

      // async reset mid WR_REQ
      do_start(32'h100, 32'h200, 16'd1, 1'b0);
      n = 0;
      for (int c = 0; c < 50 && !io_write; c++) begin @(negedge pclk); n++; end
      chk("rst_reach_wr", 64'(io_write), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", 64'({io_write, busy, err}), 64'b000);
      chk("rst_addr", 64'(io_addr), 64'd0);
      @(negedge pclk); rst_n = 1'b1;
      wait_cfg = 0;

      // abort in IDLE ignored
      @(negedge pclk); abort = 1'b1;
      @(negedge pclk); abort = 1'b0;
      @(negedge pclk);
      chk("abort_idle", 64'({err, busy}), 64'b00);

      // start and abort together in IDLE: start wins
      do_start(32'h100, 32'h200, 16'd1, 1'b1);
      chk("start_abort_busy", 64'(busy), 64'd1);
      wait_idle(nb, nd);
      chk("start_abort_result", 64'({err, 1'b0}) | 64'(nd), 64'd1);

      // bus protocol invariants over the whole run
      chk("never_rd_and_wr", 64'(n_both), 64'd0);
      chk("rr_single_cycle", 64'(n_rr2), 64'd0);
      chk("no_req_while_ready", 64'(n_early), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
